// File: rtl/expr_pkg.sv
// Shared definitions for the expression-string generator: FSM state encoding,
// 2-bit operator codes and the ASCII characters the generator can emit.
package expr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        OP    = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_DIV   = 8'h2F;

endpackage

// File: rtl/expr_char_enc.sv
// Combinational character encoder: maps a digit value or an operator code to
// its ASCII byte. Digit values above 9 saturate to '9'.
// Ports:
//   is_digit - 1 selects the operand path, 0 the operator path
//   opnd     - 4-bit operand value
//   op       - 2-bit operator code
//   ch_c     - ASCII character (combinational)
module expr_char_enc
    import expr_pkg::*;
(
    input  logic       is_digit,
    input  logic [3:0] opnd,
    input  logic [1:0] op,
    output logic [7:0] ch_c
);

    always_comb begin
        ch_c = CH_0;
        if (is_digit) begin
            ch_c = (opnd > 4'd9) ? CH_9 : (CH_0 + 8'(opnd));
        end else begin
            case (op)
                OP_ADD:  ch_c = CH_PLUS;
                OP_SUB:  ch_c = CH_MINUS;
                OP_MUL:  ch_c = CH_MUL;
                default: ch_c = CH_DIV;
            endcase
        end
    end

endmodule

// File: rtl/expr_string_gen.sv
// Expression-string generator: serialises a latched list of single-digit
// operands and binary operators into an ASCII stream "d op d ... d", one
// character per valid/ready handshake.
// Ports:
//   clk, clr_n            - clock, asynchronous active-low reset
//   start                 - begin a new expression (sampled while idle)
//   num_operands          - operand count N (clamped to MAX_OPERANDS, 0 ignored)
//   operands, ops         - packed operand nibbles / 2-bit operator codes
//   out_data/valid/last   - registered character stream, out_last on final char
//   out_ready             - consumer accepts the current character
//   busy                  - expression in progress
// Build option: define EXPR_ERR_INJECT_EN to add input err_inject, which
// corrupts the first operator to '0' (N>=2) or appends a trailing '+' (N==1).
module expr_string_gen
    import expr_pkg::*;
#(
    parameter int unsigned MAX_OPERANDS = 8,
    parameter int unsigned CNT_W        = $clog2(MAX_OPERANDS) + 1
) (
    input  logic                        clk,
    input  logic                        clr_n,
    input  logic                        start,
    input  logic [CNT_W-1:0]            num_operands,
    input  logic [4*MAX_OPERANDS-1:0]   operands,
    input  logic [2*(MAX_OPERANDS-1)-1:0] ops,
`ifdef EXPR_ERR_INJECT_EN
    input  logic                        err_inject,
`endif
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy
);

    localparam int unsigned OPND_W = 4 * MAX_OPERANDS;
    localparam int unsigned OPS_W  = 2 * (MAX_OPERANDS - 1);

    state_t               state_q, state_nxt;
    logic [CNT_W-1:0]     idx_q, idx_nxt;
    logic [CNT_W-1:0]     neff_q, neff_nxt;
    logic [OPND_W-1:0]    opnd_q, opnd_nxt;
    logic [OPS_W-1:0]     ops_q, ops_nxt;
    logic                 err_q, err_nxt;
    logic                 err_in;

    logic [7:0]           data_nxt;
    logic                 valid_nxt, last_nxt;
    logic                 hs;
    logic                 trail_q, trail_nxt;
    logic [3:0]           opnd_sel;
    logic [1:0]           op_sel;
    logic [7:0]           enc_ch_c;

`ifdef EXPR_ERR_INJECT_EN
    assign err_in = err_inject;
`else
    assign err_in = 1'b0;
`endif

    assign hs      = out_valid && out_ready;
    // A single-operand expression with injection gets one extra '+' after the digit.
    assign trail_q = err_q && (neff_q == CNT_W'(1));

    // State, index, latches and registered outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            neff_q    <= '0;
            opnd_q    <= '0;
            ops_q     <= '0;
            err_q     <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            idx_q     <= idx_nxt;
            neff_q    <= neff_nxt;
            opnd_q    <= opnd_nxt;
            ops_q     <= ops_nxt;
            err_q     <= err_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
            out_last  <= last_nxt;
            busy      <= valid_nxt;
        end
    end

    // Next-state logic; outputs are precomputed from the next state so they
    // are registered yet aligned with the state they describe.
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        neff_nxt  = neff_q;
        opnd_nxt  = opnd_q;
        ops_nxt   = ops_q;
        err_nxt   = err_q;

        case (state_q)
            IDLE: begin
                if (start && (num_operands != '0)) begin
                    state_nxt = DIGIT;
                    idx_nxt   = '0;
                    neff_nxt  = (num_operands > CNT_W'(MAX_OPERANDS)) ?
                                CNT_W'(MAX_OPERANDS) : num_operands;
                    opnd_nxt  = operands;
                    ops_nxt   = ops;
                    err_nxt   = err_in;
                end
            end
            DIGIT: begin
                if (hs) begin
                    if (idx_q == (neff_q - CNT_W'(1))) begin
                        state_nxt = trail_q ? OP : IDLE;
                    end else begin
                        state_nxt = OP;
                    end
                end
            end
            OP: begin
                if (hs) begin
                    if (trail_q) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = idx_q + CNT_W'(1);
                        state_nxt = DIGIT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign trail_nxt = err_nxt && (neff_nxt == CNT_W'(1));
    assign opnd_sel  = 4'(opnd_nxt >> {idx_nxt, 2'b00});
    assign op_sel    = 2'(ops_nxt >> {idx_nxt, 1'b0});

    expr_char_enc u_enc (
        .is_digit (state_nxt == DIGIT),
        .opnd     (opnd_sel),
        .op       (op_sel),
        .ch_c     (enc_ch_c)
    );

    // Output values for the character presented after this edge.
    always_comb begin
        valid_nxt = (state_nxt != IDLE);
        last_nxt  = 1'b0;
        data_nxt  = 8'h00;
        case (state_nxt)
            DIGIT: begin
                data_nxt = enc_ch_c;
                last_nxt = (idx_nxt == (neff_nxt - CNT_W'(1))) && !trail_nxt;
            end
            OP: begin
                if (trail_nxt) begin
                    data_nxt = CH_PLUS;
                    last_nxt = 1'b1;
                end else if (err_nxt && (idx_nxt == '0)) begin
                    data_nxt = CH_0;
                end else begin
                    data_nxt = enc_ch_c;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/expr_string_gen.md
Name: expr_string_gen

Overview:
- Transmit-side counterpart of the expression-string recognizer.
- Serialises a latched list of single-digit operands and binary operators into an ASCII byte stream of the form digit, op, digit, ..., digit: one character per accepted handshake.
- Drives the recognizer's 8-bit character input in self-checking benches, and feeds any downstream expression consumer.

Parameters:
- MAX_OPERANDS, 8, maximum operand count per expression (>=1).
- CNT_W, $clog2(MAX_OPERANDS)+1, width of operand-count input and internal counters.

Ports:
- clk  in  1  single clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  request to serialise a new expression; sampled only when busy=0.
- num_operands  in  CNT_W  operand count N.
- operands  in  4*MAX_OPERANDS  packed operand values; operand i at bits [4i+3:4i].
- ops  in  2*(MAX_OPERANDS-1)  packed operators; op i at [2i+1:2i]; 00 '+', 01 '-', 10 '*', 11 '/'.
- out_data  out  8  ASCII character.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_last  out  1  current character is the final digit.
- busy  out  1  expression in progress.

Behaviour:
- Reset (clr_n low, asynchronous): state IDLE; out_valid=0, out_last=0, busy=0, out_data=8'h00; all counters cleared.
- Reset mid-stream: transfer aborts immediately, no completion indication; the next start after reset is handled normally.
- IDLE:
  - start=1 with 1<=N: latch operands, ops and N_eff=min(N,MAX_OPERANDS); go to DIGIT next edge. busy and out_valid rise one cycle after start.
  - start=1 with N=0: ignored; stay IDLE; no output.
- DIGIT:
  - out_data = 8'h30 + operand[idx]; operand values 10..15 saturate to '9' (8'h39).
  - out_last=1 when idx==N_eff-1.
  - On out_valid&&out_ready: if last, go to IDLE (busy, out_valid fall next cycle); otherwise go to OP.
- OP:
  - out_data = ASCII of op[idx] ('+' 8'h2B, '-' 8'h2D, '*' 8'h2A, '/' 8'h2F); out_last=0.
  - On handshake: idx++, go to DIGIT.
- Handshake rules:
  - out_valid, once high, stays high until accepted.
  - out_data and out_last stay stable while out_valid&&!out_ready.
  - No combinational path from out_ready to out_valid.
- Stream length is exactly 2*N_eff-1 characters; one character per cycle at full throughput.
- start while busy=1 is ignored; inputs changing after latch have no effect.
- Back-to-back: start may be asserted in the cycle after the last handshake (busy=0). Minimum one idle cycle between expressions.

Optional Feature:
- Macro EXPR_ERR_INJECT_EN.
- Defined:
  - Adds input err_inject (1 bit), sampled with start.
  - If set and N_eff>=2, the first operator character is replaced by '0' (8'h30), producing a string the recognizer must reject.
  - If set and N_eff==1, an extra trailing '+' is emitted after the digit; out_last then marks the '+'.
- Undefined: port absent; streams always well-formed.

Decomposition:
- Package expr_pkg holds:
  - state encoding IDLE/DIGIT/OP;
  - op encoding constants OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - ASCII constants CH_0, CH_9, CH_PLUS, CH_MINUS, CH_MUL, CH_DIV.
- One sub-module is natural: expr_char_enc, a combinational mapping of (is_digit, 4-bit operand, 2-bit op) to an 8-bit ASCII value, including digit saturation.
- FSM, index counter and latches stay in the top module.

Test Plan:
- N=3, operands {1,2,3}, ops {00,10}, out_ready=1 -> 5 consecutive cycles "1","+","2","*","3"; out_last only on "3"; busy low the cycle after.
- Same stream with out_ready toggling 1,0,0,1,... -> each character held stable while stalled; identical sequence; no duplicates or drops.
- N=1, operand 7 -> single "7" with out_last=1. N=0 -> no out_valid, busy stays 0.
- N=12 (> MAX_OPERANDS=8), operand value 13 in slot 0 -> 15 characters; first is "9".
- clr_n pulsed low after the 2nd character -> out_valid/busy drop asynchronously; a fresh start with N=2 then yields exactly 3 characters.
- EXPR_ERR_INJECT_EN defined, err_inject=1, N=2 {4,5}, op 01 -> "4","0","5"; N=1 {6} -> "6","+", with out_last on "+".
